// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD adder/subtractor, one digit per clock, LSD first.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   Start  - begin an operation (accepted in IDLE or DONE, ignored in RUN)
//   Sub    - 0: A+B, 1: A-B (ten's complement)
//   A, B   - packed BCD operands, LSD in [3:0]
//   Cin    - carry-in (add) / borrow-in (sub)
//   Busy   - operation in progress
//   Done   - one-cycle result-valid pulse
//   S      - packed BCD result, held until the next Done
//   Cout   - final decimal carry (sub: 1 = no borrow)
//   Neg    - result negative (sub only)
//   Err    - invalid operand digit seen (only with BCD_DIGIT_CHECK_EN)
//
// Build option: define BCD_DIGIT_CHECK_EN to flag operand digits above 9. Without it Err is
// tied low and such digits are processed arithmetically.
module bcd_serial_addsub #(
  parameter int unsigned DIGIT_NUM = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Start,
  input  logic                   Sub,
  input  logic [4*DIGIT_NUM-1:0] A,
  input  logic [4*DIGIT_NUM-1:0] B,
  input  logic                   Cin,
  output logic                   Busy,
  output logic                   Done,
  output logic [4*DIGIT_NUM-1:0] S,
  output logic                   Cout,
  output logic                   Neg,
  output logic                   Err
);

  localparam int unsigned W  = 4 * DIGIT_NUM;
  localparam int unsigned IW = $clog2(DIGIT_NUM);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(DIGIT_NUM - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  a_q, b_q;     // shift right one digit per cycle
  logic [W-1:0]  acc_q;        // result digits enter at the top
  logic          sub_q;
  logic          c_q;          // running decimal carry
  logic [W-1:0]  s_q;
  logic          cout_q, neg_q;

  logic [3:0]    b_eff;
  logic [4:0]    dsum, dadj;
  logic [3:0]    d_out;
  logic          c_out;
  logic [W-1:0]  result;
  logic          last;
  logic          accept;

  assign last   = (idx_q == LAST_IDX);
  assign accept = Start && (state_q != RUN);
  assign result = {d_out, acc_q[W-1:4]};

  // One BCD digit: nine's complement of B when subtracting, +6 correction above 9.
  always_comb begin
    b_eff = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    dsum  = {1'b0, a_q[3:0]} + {1'b0, b_eff} + {4'b0000, c_q};
    dadj  = dsum + 5'd6;
    if (dsum > 5'd9) begin
      d_out = dadj[3:0];
      c_out = 1'b1;
    end else begin
      d_out = dsum[3:0];
      c_out = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = Start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q;     // sticky: some processed digit was invalid
  logic err_o_q;
  logic dig_bad;
  logic err_any;

  assign dig_bad = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
  assign err_any = err_q | dig_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      err_o_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_q == RUN) begin
      err_q <= err_any;
      if (last) err_o_q <= err_any;
    end
  end

  assign Err = err_o_q;
`else
  logic err_any;
  assign err_any = 1'b0;
  assign Err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        sub_q <= Sub;
        // Subtraction is A + (9..9 - B) + 1, so a borrow-in removes the +1.
        c_q   <= Sub ? ~Cin : Cin;
        idx_q <= '0;
      end else if (state_q == RUN) begin
        a_q   <= a_q >> 4;
        b_q   <= b_q >> 4;
        acc_q <= result;
        c_q   <= c_out;
        idx_q <= last ? '0 : idx_q + 1'b1;
        if (last) begin
          if (err_any) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            neg_q  <= 1'b0;
          end else begin
            s_q    <= result;
            cout_q <= c_out;
            neg_q  <= sub_q & ~c_out;
          end
        end
      end
    end
  end

  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign Neg  = neg_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

  localparam int N = 8;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Sub = 1'b0;
  logic         Cin = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Done, Cout, Neg, Err;
  logic [W-1:0] S;

  int checks = 0;
  int failures = 0;

  bcd_serial_addsub #(.DIGIT_NUM(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .S     (S),
    .Cout  (Cout),
    .Neg   (Neg),
    .Err   (Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (integer arithmetic) ----------------
  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Returns {err, neg, cout, s}.
  function automatic logic [W+2:0] predict(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic cin);
    longint p = 1;
    longint t;
    logic err = 1'b0;
    logic cout;
    logic [W-1:0] s;
    for (int i = 0; i < N; i++) p = p * 10;
`ifdef BCD_DIGIT_CHECK_EN
    for (int i = 0; i < N; i++) if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) err = 1'b1;
`endif
    if (err) return {1'b1, 1'b0, 1'b0, {W{1'b0}}};
    if (!sub) begin
      t    = bcd2int(a) + bcd2int(b) + longint'(cin);
      cout = (t >= p);
      s    = int2bcd(t % p);
    end else begin
      t    = bcd2int(a) - bcd2int(b) - longint'(cin);
      cout = (t >= 0);
      s    = int2bcd(t < 0 ? t + p : t);
    end
    return {1'b0, sub & ~cout, cout, s};
  endfunction

  int           m_rem = 0;    // busy cycles left
  logic         m_done = 1'b0;
  logic [W+2:0] m_pend = '0;
  logic [W+2:0] m_out = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
    end else if (m_rem > 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_out <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (Start) begin
        m_rem  <= N;
        m_pend <= predict(A, B, Sub, Cin);
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("cyc_busy", Busy, m_rem > 0);
      chk("cyc_done", Done, m_done);
      chk("cyc_s", S, m_out[W-1:0]);
      chk("cyc_cout", Cout, m_out[W]);
      chk("cyc_neg", Neg, m_out[W+1]);
      chk("cyc_err", Err, m_out[W+2]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic cin);
    @(negedge clk);
    A = a; B = b; Sub = sub; Cin = cin; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  // Counts edges after the Start edge up to and including the one that raises Done.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!Done && n < 40);
    chk("done_seen", Done, 1'b1);
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic [W-1:0] s;
    logic         cout, neg;
  } vec_t;

  vec_t vecs[8];
  int   n;

  initial begin
    vecs[0] = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
    vecs[1] = '{32'h99999999, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'h99999998, 1'b0, 1'b1};
    vecs[3] = '{32'h00000050, 32'h00000007, 1'b1, 1'b0, 32'h00000043, 1'b1, 1'b0};
    vecs[4] = '{32'h00000999, 32'h00000001, 1'b0, 1'b1, 32'h00001001, 1'b0, 1'b0};
    vecs[5] = '{32'h00001000, 32'h00000001, 1'b1, 1'b1, 32'h00000998, 1'b1, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h99999999, 1'b0, 1'b1};
    vecs[7] = '{32'h50000000, 32'h50000000, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_s", S, '0);
    chk("rst_err", Err, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      chk($sformatf("op%0d_busy", i), Busy, 1'b1);
      wait_done(n);
      chk($sformatf("op%0d_latency", i), n, N);
      chk($sformatf("op%0d_s", i), S, vecs[i].s);
      chk($sformatf("op%0d_cout", i), Cout, vecs[i].cout);
      chk($sformatf("op%0d_neg", i), Neg, vecs[i].neg);
      chk($sformatf("op%0d_model_s", i), m_out[W-1:0], vecs[i].s);
    end

    // Start mid-RUN is ignored
    start_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    A = 32'h99999999; B = 32'h99999999; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    wait_done(n);
    chk("midrun_s", S, 32'h33333333);

    // Start during DONE: straight back into RUN
    A = 32'h00000002; B = 32'h00000003; Sub = 1'b0; Cin = 1'b0; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    chk("done_restart_busy", Busy, 1'b1);
    chk("done_restart_done", Done, 1'b0);
    wait_done(n);
    chk("done_restart_latency", n, N);
    chk("done_restart_s", S, 32'h00000005);

    // Invalid digit
    start_op(32'h0000000A, 32'h00000001, 1'b0, 1'b0);
    wait_done(n);
`ifdef BCD_DIGIT_CHECK_EN
    chk("bad_digit_err", Err, 1'b1);
    chk("bad_digit_s", S, 32'h00000000);
`else
    chk("bad_digit_err", Err, 1'b0);
    chk("bad_digit_s", S, 32'h00000011);
`endif

    // Reset after 4 digits processed
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_s", S, '0);
    chk("abort_cout", Cout, 1'b0);
    chk("abort_neg", Neg, 1'b0);
    chk("abort_err", Err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    A = 32'h00000001; B = 32'h00000001; Sub = 1'b0; Cin = 1'b0; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    chk("post_rst_busy", Busy, 1'b1);
    wait_done(n);
    chk("post_rst_latency", n, N);
    chk("post_rst_s", S, 32'h00000002);

    repeat (4) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
